uart_tx_ctrl: RTL and testbench

UART transmit controller that sequences the baud timer to serialize one byte per request onto the tx line.
- Frame: start bit, DBIT data bits LSB-first, optional parity bit, stop bit(s).
- Owns one baud-tick timer instance. Gates and clears the timer per frame, so every frame starts phase-aligned.
- Sits between the host-side byte interface and the UART pin. It is the transmit-side consumer of the baud generator.

---
 rtl/uart_pkg.sv | 19 +
 rtl/uart_baud_timer.sv | 31 +++
 rtl/uart_tx_ctrl.sv | 173 +++++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding, oversample rate and default
// parameter values used by the transmit (and future receive) controllers.
package uart_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4
  } uart_state_t;

  localparam int OVERSAMPLE  = 16;

  localparam int DEF_BITS    = 11;
  localparam int DEF_DBIT    = 8;
  localparam int DEF_SB_TICK = 16;

endpackage

// File: rtl/uart_baud_timer.sv
// Baud tick timer: counts 0..final_value and pulses tick on the terminal
// count. Held at zero while disabled; clear restarts it in phase.
module uart_baud_timer
  import uart_pkg::*;
#(
  parameter int BITS = DEF_BITS
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic            enable,
  input  logic            clear,
  input  logic [BITS-1:0] final_value,
  output logic            tick
);

  logic [BITS-1:0] count;

  // Free-running divider count, wrapping on the tick edge.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count <= '0;
    end else if (clear || !enable || (count == final_value)) begin
      count <= '0;
    end else begin
      count <= count + 1'b1;
    end
  end

  assign tick = enable && !clear && (count == final_value);

endmodule

// File: rtl/uart_tx_ctrl.sv
// UART transmit controller: serializes one byte per accepted request as
// start bit, DBIT data bits LSB-first, optional parity bit, stop period.
// Optional feature macro: UART_TX_PARITY_EN (adds parity_odd port and a
// PARITY state between DATA and STOP).
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int BITS    = DEF_BITS,
  parameter int DBIT    = DEF_DBIT,
  parameter int SB_TICK = DEF_SB_TICK
) (
  input  logic            clk,
  input  logic            reset_n,
  input  logic [BITS-1:0] baud_div,
  input  logic            tx_start,
  input  logic [DBIT-1:0] tx_data,
`ifdef UART_TX_PARITY_EN
  input  logic            parity_odd,
`endif
  output logic            tx_ready,
  output logic            tx_done_tick,
  output logic            tx
);

  localparam int NW = (DBIT > 1) ? $clog2(DBIT) : 1;

  uart_state_t     state, state_next;
  logic [DBIT-1:0] shift_q, shift_next;
  logic [4:0]      s_q, s_next;
  logic [NW-1:0]   n_q, n_next;
  logic [BITS-1:0] div_q, div_next;
  logic            tx_next, ready_next, done_next;
  logic            tick, accept, timer_en;
`ifdef UART_TX_PARITY_EN
  logic            par_q, par_next;
`endif

  assign accept   = (state == ST_IDLE) && tx_start;
  assign timer_en = (state != ST_IDLE);

  uart_baud_timer #(.BITS(BITS)) u_timer (
    .clk        (clk),
    .reset_n    (reset_n),
    .enable     (timer_en),
    .clear      (accept),
    .final_value(div_q),
    .tick       (tick)
  );

  // State, datapath and registered outputs.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state        <= ST_IDLE;
      shift_q      <= '0;
      s_q          <= '0;
      n_q          <= '0;
      div_q        <= '0;
      tx           <= 1'b1;
      tx_ready     <= 1'b1;
      tx_done_tick <= 1'b0;
`ifdef UART_TX_PARITY_EN
      par_q        <= 1'b0;
`endif
    end else begin
      state        <= state_next;
      shift_q      <= shift_next;
      s_q          <= s_next;
      n_q          <= n_next;
      div_q        <= div_next;
      tx           <= tx_next;
      tx_ready     <= ready_next;
      tx_done_tick <= done_next;
`ifdef UART_TX_PARITY_EN
      par_q        <= par_next;
`endif
    end
  end

  // Next-state and datapath update, advancing one oversample tick at a time.
  always_comb begin
    state_next = state;
    shift_next = shift_q;
    s_next     = s_q;
    n_next     = n_q;
    div_next   = div_q;
`ifdef UART_TX_PARITY_EN
    par_next   = par_q;
`endif
    case (state)
      ST_IDLE: begin
        if (tx_start) begin
          shift_next = tx_data;
          div_next   = baud_div;
          s_next     = '0;
          n_next     = '0;
`ifdef UART_TX_PARITY_EN
          par_next   = (^tx_data) ^ parity_odd;
`endif
          state_next = ST_START;
        end
      end
      ST_START: begin
        if (tick) begin
          if (s_q == 5'(OVERSAMPLE - 1)) begin
            s_next     = '0;
            state_next = ST_DATA;
          end else begin
            s_next = s_q + 5'd1;
          end
        end
      end
      ST_DATA: begin
        if (tick) begin
          if (s_q == 5'(OVERSAMPLE - 1)) begin
            s_next     = '0;
            shift_next = shift_q >> 1;
            if (n_q == NW'(DBIT - 1)) begin
`ifdef UART_TX_PARITY_EN
              state_next = ST_PARITY;
`else
              state_next = ST_STOP;
`endif
            end else begin
              n_next = n_q + 1'b1;
            end
          end else begin
            s_next = s_q + 5'd1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      ST_PARITY: begin
        if (tick) begin
          if (s_q == 5'(OVERSAMPLE - 1)) begin
            s_next     = '0;
            state_next = ST_STOP;
          end else begin
            s_next = s_q + 5'd1;
          end
        end
      end
`endif
      ST_STOP: begin
        if (tick) begin
          if (s_q == 5'(SB_TICK - 1)) begin
            s_next     = '0;
            state_next = ST_IDLE;
          end else begin
            s_next = s_q + 5'd1;
          end
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  // Output values derived from the upcoming state so the registered line
  // changes on the same edge the state does.
  always_comb begin
    done_next  = (state == ST_STOP) && (state_next == ST_IDLE);
    ready_next = (state_next == ST_IDLE);
    tx_next    = 1'b1;
    case (state_next)
      ST_START:  tx_next = 1'b0;
      ST_DATA:   tx_next = shift_next[0];
`ifdef UART_TX_PARITY_EN
      ST_PARITY: tx_next = par_next;
`endif
      default:   tx_next = 1'b1;
    endcase
  end

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Self-checking bench for uart_tx_ctrl: a per-cycle reference model of the
// serial frame, a table of directed frames, hand-written corner sequences
// and randomized frames.
module tb_uart_tx_ctrl;

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif
  localparam int NB      = 1 + 8 + P;         // bits before the stop period
  localparam int FRAME_T = NB * 16 + 16;      // oversample ticks per frame
  localparam int LIMIT   = 20000;

  logic        clk;
  logic        reset_n;
  logic [10:0] baud_div;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        parity_odd;
  logic        tx_ready, tx_done_tick, tx;

  int total = 0;
  int bad   = 0;

  uart_tx_ctrl #(.BITS(11), .DBIT(8), .SB_TICK(16)) dut (
    .clk         (clk),
    .reset_n     (reset_n),
    .baud_div    (baud_div),
    .tx_start    (tx_start),
    .tx_data     (tx_data),
`ifdef UART_TX_PARITY_EN
    .parity_odd  (parity_odd),
`endif
    .tx_ready    (tx_ready),
    .tx_done_tick(tx_done_tick),
    .tx          (tx)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Inputs as seen by the DUT at each rising edge.
  logic        smp_rst, smp_start, smp_odd;
  logic [7:0]  smp_data;
  logic [10:0] smp_div;
  always @(posedge clk) begin
    smp_rst   <= reset_n;
    smp_start <= tx_start;
    smp_data  <= tx_data;
    smp_div   <= baud_div;
    smp_odd   <= parity_odd;
  end

  // Reference model: a frame is a list of bits, each lasting 16*(div+1)
  // cycles, followed by the stop period; checked every cycle.
  initial begin
    bit          m_busy;
    int          m_t, m_len, m_bitlen, idx;
    logic [15:0] frame;
    logic        e_tx, e_rdy, e_done;
    m_busy = 0; m_t = 0; m_len = 0; m_bitlen = 16; frame = '1;
    forever begin
      @(negedge clk);
      e_tx = 1'b1; e_rdy = 1'b1; e_done = 1'b0;
      if (!reset_n || smp_rst !== 1'b1) begin
        m_busy = 0;
      end else if (m_busy) begin
        m_t++;
        if (m_t == m_len) begin
          m_busy = 0;
          e_done = 1'b1;
        end else begin
          e_rdy = 1'b0;
          idx   = m_t / m_bitlen;
          e_tx  = (idx < NB) ? frame[idx] : 1'b1;
        end
      end else if (smp_start === 1'b1) begin
        m_busy   = 1;
        m_t      = 0;
        m_bitlen = 16 * (int'(smp_div) + 1);
        m_len    = FRAME_T * (int'(smp_div) + 1);
        frame    = '1;
        frame[0] = 1'b0;
        for (int i = 0; i < 8; i++) frame[1 + i] = smp_data[i];
`ifdef UART_TX_PARITY_EN
        frame[9] = (^smp_data) ^ smp_odd;
`endif
        e_tx  = 1'b0;
        e_rdy = 1'b0;
      end
      chk("mon_tx",    {31'd0, tx},           {31'd0, e_tx});
      chk("mon_ready", {31'd0, tx_ready},     {31'd0, e_rdy});
      chk("mon_done",  {31'd0, tx_done_tick}, {31'd0, e_done});
    end
  end

  // Call just after an accept edge; samples each bit at its centre and
  // returns at the negedge where tx_done_tick is seen.
  task automatic measure(input int div, output int len, output logic [15:0] bits, output bit to);
    int bl;
    bl = 16 * (div + 1);
    bits = '1; len = -1; to = 1;
    for (int t = 0; t < LIMIT; t++) begin
      @(negedge clk);
      if ((t % bl) == bl / 2 && (t / bl) < 16) bits[t / bl] = tx;
      if (tx_done_tick === 1'b1) begin
        len = t;
        to  = 0;
        break;
      end
    end
  endtask

  task automatic check_frame(input string tag, input logic [7:0] data, input logic odd,
                             input int exp_len, input int len, input logic [15:0] bits, input bit to);
    chk({tag, "_timeout"}, {31'd0, to}, 32'd0);
    chk({tag, "_len"}, len, exp_len);
    chk({tag, "_start"}, {31'd0, bits[0]}, 32'd0);
    chk({tag, "_data"}, {24'd0, bits[8:1]}, {24'd0, data});
`ifdef UART_TX_PARITY_EN
    chk({tag, "_parity"}, {31'd0, bits[9]}, {31'd0, (^data) ^ odd});
`endif
    chk({tag, "_stop"}, {31'd0, bits[NB]}, 32'd1);
  endtask

  // Request one frame (DUT must be idle) and check its decoded contents.
  task automatic run_frame(input string tag, input logic [7:0] data, input int div, input logic odd,
                           input bit glitch, input int gdiv);
    int          len;
    logic [15:0] bits;
    bit          to;
    int          k;
    tx_data = data; baud_div = 11'(div); parity_odd = odd; tx_start = 1'b1;
    @(posedge clk); #2;
    tx_start = 1'b0;
    k = $urandom_range(5, 100);
    fork
      measure(div, len, bits, to);
      begin
        if (glitch) begin
          repeat (k) @(posedge clk);
          #2 tx_start = 1'b1; baud_div = 11'(gdiv); tx_data = 8'hE7;
          @(posedge clk);
          #2 tx_start = 1'b0;
        end
      end
    join
    check_frame(tag, data, odd, FRAME_T * (div + 1), len, bits, to);
  endtask

  typedef struct {
    logic [7:0] data;
    int         div;
    logic       odd;
  } vec_t;

  initial begin
    vec_t        vec[6];
    int          len;
    logic [15:0] bits;
    bit          to;
    int          div, gap;

    vec[0] = '{8'h55, 3, 1'b0};
    vec[1] = '{8'hFF, 0, 1'b1};
    vec[2] = '{8'h00, 1, 1'b0};
    vec[3] = '{8'h80, 2, 1'b1};
    vec[4] = '{8'hA5, 0, 1'b0};
    vec[5] = '{8'h3C, 7, 1'b1};

    baud_div = 11'd3; tx_start = 1'b0; tx_data = 8'h00; parity_odd = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    #2;
    chk("reset_tx",    {31'd0, tx},           32'd1);
    chk("reset_ready", {31'd0, tx_ready},     32'd1);
    chk("reset_done",  {31'd0, tx_done_tick}, 32'd0);
    repeat (3) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);

    // Directed table.
    for (int i = 0; i < 6; i++) begin
      run_frame("vec", vec[i].data, vec[i].div, vec[i].odd, 0, 0);
      @(negedge clk);
    end

    // Reset mid-DATA aborts the frame without waiting for a clock.
    tx_data = 8'hA5; baud_div = 11'd3; tx_start = 1'b1;
    @(posedge clk); #2;
    tx_start = 1'b0;
    repeat (199) @(posedge clk);
    #2 chk("midreset_busy", {31'd0, tx_ready}, 32'd0);
    #1 reset_n = 1'b0;
    #1;
    chk("midreset_tx",    {31'd0, tx},           32'd1);
    chk("midreset_ready", {31'd0, tx_ready},     32'd1);
    chk("midreset_done",  {31'd0, tx_done_tick}, 32'd0);
    repeat (2) @(posedge clk);
    #2 reset_n = 1'b1;
    @(negedge clk);
    run_frame("after_reset", 8'h3C, 3, 1'b0, 0, 0);

    // Back-to-back with tx_start held high.
    @(negedge clk);
    tx_data = 8'h01; baud_div = 11'd0; tx_start = 1'b1;
    @(posedge clk); #2;
    tx_data = 8'h80;
    measure(0, len, bits, to);
    check_frame("b2b_first", 8'h01, 1'b0, FRAME_T, len, bits, to);
    chk("b2b_ready_at_done", {31'd0, tx_ready}, 32'd1);
    @(posedge clk); #2;
    chk("b2b_no_gap_tx",    {31'd0, tx},       32'd0);
    chk("b2b_no_gap_ready", {31'd0, tx_ready}, 32'd0);
    tx_start = 1'b0;
    measure(0, len, bits, to);
    check_frame("b2b_second", 8'h80, 1'b0, FRAME_T, len, bits, to);

    // Mid-frame tx_start and baud_div change are ignored until the next frame.
    @(negedge clk);
    run_frame("midchg", 8'hC3, 3, 1'b0, 1, 7);
    repeat (3) @(negedge clk);
    chk("midchg_not_queued", {31'd0, tx_ready}, 32'd1);
    tx_data = 8'h5A; tx_start = 1'b1;
    @(posedge clk); #2;
    tx_start = 1'b0;
    measure(7, len, bits, to);
    check_frame("newdiv", 8'h5A, 1'b0, FRAME_T * 8, len, bits, to);

`ifdef UART_TX_PARITY_EN
    @(negedge clk);
    tx_data = 8'h07; baud_div = 11'd3; parity_odd = 1'b0; tx_start = 1'b1;
    @(posedge clk); #2 tx_start = 1'b0;
    measure(3, len, bits, to);
    chk("par_even_bit", {31'd0, bits[9]}, 32'd1);
    chk("par_even_len", len, 704);
    @(negedge clk);
    tx_data = 8'h07; parity_odd = 1'b1; tx_start = 1'b1;
    @(posedge clk); #2 tx_start = 1'b0;
    measure(3, len, bits, to);
    chk("par_odd_bit", {31'd0, bits[9]}, 32'd0);
    chk("par_odd_len", len, 704);
`endif

    // Randomized frames, gaps (including zero) and mid-frame disturbances.
    for (int i = 0; i < 15; i++) begin
      gap = $urandom_range(0, 4);
      repeat (gap) @(negedge clk);
      div = $urandom_range(0, 3);
      run_frame("rnd", 8'($urandom), div, 1'($urandom), 1'($urandom), $urandom_range(0, 3));
    end

    repeat (4) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
